// File: rtl/miss_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: the miss FSM state encoding and the
// default sizing constants used by the data- and instruction-side stall controls.
package miss_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        REFILL = 2'd3
    } state_e;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/miss_stall_ctrl.sv
// Data-cache miss stall controller: freezes the pipeline on a MEM-stage miss,
// runs the refill handshake, and qualifies hazard hold and branch flush.
module miss_stall_ctrl
    import miss_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_req_i,
    input  logic             cache_hit_i,
    input  logic             mem_ack_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             hd_o,
    output logic             flush_o,
    output logic             pc_write_o,
    output logic             mem_rd_o,
    output logic             cache_we_o,
    output logic             retry_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_next_s;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic              miss_s;
    logic              miss_take_s;
    logic              retry_set_s;
    logic              stall_s;
    logic              hd_s;
    logic              mem_rd_r;
    logic              cache_we_r;
    logic              retry_r;

    // Next-state and wait-counter logic; ack only matters in WAIT and beats the timeout.
    always_comb begin
        miss_s          = mem_req_i & ~cache_hit_i;
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        miss_take_s     = 1'b0;
        retry_set_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    state_next_s = REQ;
                    miss_take_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                wait_cnt_next_s = '0;
                state_next_s    = WAIT;
            end
            WAIT: begin
                if (mem_ack_i) begin
                    state_next_s = REFILL;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = REQ;
                    retry_set_s  = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WCNT_W'(1);
                end
            end
            REFILL: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pipeline qualifiers: stall beats hazard hold, hazard hold beats flush.
    always_comb begin
        stall_s = miss_s | (state_r != IDLE);
        hd_s    = load_use_i & ~stall_s;
        if (state_r == IDLE) begin
            stall_s = miss_s;
        end else begin
            stall_s = 1'b1;
            hd_s    = 1'b0;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Miss performance counter; retries are not counted, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            miss_cnt_r <= '0;
        end else if (miss_take_s) begin
            miss_cnt_r <= miss_cnt_r + CNT_W'(1);
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    // Memory-side strobes registered so each is high exactly during its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_rd_r   <= 1'b0;
            cache_we_r <= 1'b0;
            retry_r    <= 1'b0;
        end else begin
            mem_rd_r   <= (state_next_s == REQ);
            cache_we_r <= (state_next_s == REFILL);
            retry_r    <= retry_set_s;
        end
    end

    assign stall_o    = stall_s;
    assign hd_o       = load_use_i & ~stall_s;
    assign flush_o    = branch_taken_i & ~stall_s & ~hd_s;
    assign pc_write_o = ~(stall_s | hd_s);
    assign mem_rd_o   = mem_rd_r;
    assign cache_we_o = cache_we_r;
    assign retry_o    = retry_r;
    assign miss_cnt_o = miss_cnt_r;

endmodule

// File: tb/tb_miss_stall_ctrl.sv
// Directed bench for miss_stall_ctrl: table of IDLE qualifier vectors plus
// hand-written miss, timeout, branch-across-miss and mid-miss reset sequences.
module tb_miss_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        cache_hit = 1'b0;
    logic        mem_ack = 1'b0;
    logic        load_use = 1'b0;
    logic        branch = 1'b0;
    logic        stall, hd, flush, pc_write, mem_rd, cache_we, retry;
    logic [15:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic lu, br, req, hit;
        logic stall, hd, flush, pcw;
    } vec_t;

    typedef struct {
        int stall, rd, we, retry, pcw_bad, flush_bad, post_flush;
    } res_t;

    vec_t vecs[8];
    res_t r;

    miss_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(mem_req), .cache_hit_i(cache_hit),
        .mem_ack_i(mem_ack), .load_use_i(load_use), .branch_taken_i(branch),
        .stall_o(stall), .hd_o(hd), .flush_o(flush), .pc_write_o(pc_write),
        .mem_rd_o(mem_rd), .cache_we_o(cache_we), .retry_o(retry), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Run a miss for ncyc cycles; ack the ack_attempt-th request ack_delay cycles after its mem_rd.
    task automatic run_miss(input int ack_attempt, input int ack_delay, input int ncyc, output res_t res);
        int rd_seen = 0;
        int ack_at = -1;
        bit refill_seen = 0;
        bit captured = 0;
        res = '{default: 0};
        res.post_flush = -1;
        mem_req = 1'b1;
        cache_hit = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            mem_ack = (c == ack_at);
            #2;
            if (stall) begin
                res.stall++;
                if (pc_write) res.pcw_bad++;
                if (flush) res.flush_bad++;
            end else if (refill_seen && !captured) begin
                res.post_flush = int'(flush);
                captured = 1;
            end
            if (mem_rd) begin
                res.rd++;
                rd_seen++;
                if (rd_seen == ack_attempt) ack_at = c + ack_delay;
            end
            if (retry) res.retry++;
            if (cache_we) begin
                res.we++;
                refill_seen = 1;
            end
            next_cycle();
            if (refill_seen) cache_hit = 1'b1;
        end
        mem_ack = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        vecs[0] = '{lu:0, br:0, req:0, hit:0, stall:0, hd:0, flush:0, pcw:1};
        vecs[1] = '{lu:1, br:0, req:0, hit:0, stall:0, hd:1, flush:0, pcw:0};
        vecs[2] = '{lu:0, br:1, req:0, hit:0, stall:0, hd:0, flush:1, pcw:1};
        vecs[3] = '{lu:1, br:1, req:0, hit:0, stall:0, hd:1, flush:0, pcw:0};
        vecs[4] = '{lu:0, br:0, req:1, hit:1, stall:0, hd:0, flush:0, pcw:1};
        vecs[5] = '{lu:1, br:1, req:1, hit:1, stall:0, hd:1, flush:0, pcw:0};
        vecs[6] = '{lu:0, br:1, req:1, hit:1, stall:0, hd:0, flush:1, pcw:1};
        vecs[7] = '{lu:0, br:0, req:0, hit:1, stall:0, hd:0, flush:0, pcw:1};

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst_stall", int'(stall), 0);
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_cache_we", int'(cache_we), 0);
        check("rst_retry", int'(retry), 0);
        check("rst_miss_cnt", int'(miss_cnt), 0);
        check("rst_pc_write", int'(pc_write), 1);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Hits never stall
        mem_req = 1'b1;
        cache_hit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("hit_stall", int'(stall), 0);
            check("hit_pc_write", int'(pc_write), 1);
            check("hit_miss_cnt", int'(miss_cnt), 0);
            next_cycle();
        end

        // IDLE qualifier table
        for (int i = 0; i < 8; i++) begin
            load_use = vecs[i].lu;
            branch = vecs[i].br;
            mem_req = vecs[i].req;
            cache_hit = vecs[i].hit;
            #2;
            check($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].stall));
            check($sformatf("vec%0d_hd", i), int'(hd), int'(vecs[i].hd));
            check($sformatf("vec%0d_flush", i), int'(flush), int'(vecs[i].flush));
            check($sformatf("vec%0d_pcw", i), int'(pc_write), int'(vecs[i].pcw));
            next_cycle();
        end

        // Load-use and branch together, then branch alone
        load_use = 1'b1;
        branch = 1'b1;
        mem_req = 1'b1;
        cache_hit = 1'b1;
        #2;
        check("lu_br_hd", int'(hd), 1);
        check("lu_br_flush", int'(flush), 0);
        check("lu_br_pcw", int'(pc_write), 0);
        next_cycle();
        load_use = 1'b0;
        #2;
        check("br_after_flush", int'(flush), 1);
        next_cycle();
        branch = 1'b0;
        mem_req = 1'b0;

        // Miss, ack 3 cycles after mem_rd
        run_miss(1, 3, 10, r);
        check("m1_stall_cycles", r.stall, 6);
        check("m1_rd_pulses", r.rd, 1);
        check("m1_we_pulses", r.we, 1);
        check("m1_retry", r.retry, 0);
        check("m1_pcw_during_stall", r.pcw_bad, 0);
        check("m1_post_flush", r.post_flush, 0);
        check("m1_miss_cnt", int'(miss_cnt), 1);

        // No ack on first attempt: timeout, retry, ack second attempt
        run_miss(2, 1, 12, r);
        check("m2_stall_cycles", r.stall, 9);
        check("m2_rd_pulses", r.rd, 2);
        check("m2_retry", r.retry, 1);
        check("m2_we_pulses", r.we, 1);
        check("m2_miss_cnt", int'(miss_cnt), 2);

        // Ack on the timeout cycle wins
        run_miss(1, 4, 12, r);
        check("m3_stall_cycles", r.stall, 7);
        check("m3_retry", r.retry, 0);
        check("m3_rd_pulses", r.rd, 1);
        check("m3_we_pulses", r.we, 1);
        check("m3_miss_cnt", int'(miss_cnt), 3);

        // Branch held across a miss flushes on first unstalled cycle
        branch = 1'b1;
        run_miss(1, 3, 10, r);
        check("m4_flush_during_stall", r.flush_bad, 0);
        check("m4_post_flush", r.post_flush, 1);
        check("m4_miss_cnt", int'(miss_cnt), 4);
        branch = 1'b0;

        // Reset mid-WAIT, then a late ack
        mem_req = 1'b1;
        cache_hit = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        #1;
        check("pre_rst_stall", int'(stall), 1);
        mem_req = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_stall", int'(stall), 0);
        check("arst_pcw", int'(pc_write), 1);
        check("arst_mem_rd", int'(mem_rd), 0);
        check("arst_miss_cnt", int'(miss_cnt), 0);
        next_cycle();
        rst = 1'b0;
        mem_ack = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("late_ack_we", int'(cache_we), 0);
            check("late_ack_stall", int'(stall), 0);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/miss_stall_ctrl.md
Name: miss_stall_ctrl

Overview:
- Pipeline control block that drives the hold/flush inputs of every stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Turns a MEM-stage data-cache miss into a multi-cycle pipeline-wide stall, and runs the refill handshake with the memory side.
- Qualifies the load-use hazard and branch flush so that stall > hazard hold > flush, the same priority the stage registers apply.

Parameters:
- TIMEOUT, 64, max WAIT cycles before the memory request is re-issued.
- CNT_W, 16, width of the miss performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_i  in  1  MEM stage holds a valid load/store this cycle.
- cache_hit_i  in  1  data cache tag hit for the MEM-stage access.
- mem_ack_i  in  1  memory returns the refill line (1-cycle pulse).
- load_use_i  in  1  raw load-use hazard from the ID-stage comparator.
- branch_taken_i  in  1  EX-stage branch resolved taken.
- stall_o  out  1  freeze all stage registers.
- hd_o  out  1  hazard hold for the IF/ID register.
- flush_o  out  1  zero the IF/ID register.
- pc_write_o  out  1  PC update enable.
- mem_rd_o  out  1  refill request strobe to memory.
- cache_we_o  out  1  write the refill line into the cache.
- retry_o  out  1  pulse when a timed-out request is re-issued.
- miss_cnt_o  out  CNT_W  count of misses taken.

Behaviour:
- FSM states: IDLE, REQ, WAIT, REFILL. Held in a register.
- Reset, asynchronous on rst_i high, from any state including mid-miss:
  - state=IDLE, wait counter=0, miss_cnt_o=0.
  - All registered pulses are 0.
  - Combinational outputs follow their inputs in IDLE.
- IDLE:
  - If mem_req_i & ~cache_hit_i, go to REQ and increment miss_cnt_o. The counter wraps modulo 2^CNT_W.
  - Otherwise stay in IDLE.
- REQ:
  - mem_rd_o=1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - If mem_ack_i, go to REFILL.
  - Else if the wait counter equals TIMEOUT-1, go to REQ and pulse retry_o for 1 cycle. miss_cnt_o does not increment on a retry.
  - Else increment the wait counter.
  - If mem_ack_i arrives on the timeout cycle, ack wins and the FSM goes to REFILL.
- REFILL:
  - cache_we_o=1 for exactly this cycle.
  - Go to IDLE. The next cycle sees cache_hit_i=1 and the pipeline proceeds.
- mem_ack_i is ignored outside WAIT.
- stall_o is combinational (Mealy), so the stage registers freeze on the same edge the miss is detected:
  - stall_o = (IDLE & mem_req_i & ~cache_hit_i) | (state != IDLE).
- hd_o = load_use_i & ~stall_o.
- flush_o = branch_taken_i & ~stall_o & ~hd_o.
  - A branch that is taken during a stall stays held in EX and flushes on the first unstalled cycle. No pending register is needed.
- pc_write_o = ~(stall_o | hd_o).
- Minimum miss penalty, counting stall_o-high cycles with ack on the first WAIT cycle: 4. The breakdown is IDLE-detect, REQ, WAIT, REFILL.
- Back-to-back misses: IDLE always gets at least 1 cycle between misses. The returning IDLE cycle re-evaluates the hit for the next access.

Decomposition:
- Shared pipeline package holds:
  - the state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, REFILL=2'd3);
  - the default TIMEOUT and CNT_W constants, reused by the instruction-side stall control.
- No sub-module. The wait counter and miss counter are inline registers.

Test Plan:
- Reset, then mem_req_i=1, cache_hit_i=1 for 5 cycles:
  - stall_o=0, pc_write_o=1, miss_cnt_o=0 throughout.
- Miss with mem_ack_i 3 cycles after mem_rd_o:
  - stall_o high for 6 cycles.
  - mem_rd_o and cache_we_o each pulse once.
  - miss_cnt_o=1.
  - pc_write_o=0 for the whole stall.
- Miss with no ack, TIMEOUT=4:
  - retry_o pulses after 4 WAIT cycles and mem_rd_o re-pulses.
  - Ack on the 2nd attempt leads to REFILL then IDLE.
  - miss_cnt_o=1.
- load_use_i=1 and branch_taken_i=1 together during IDLE with a hit:
  - hd_o=1, flush_o=0, pc_write_o=0.
  - Next cycle, with load_use_i=0, flush_o=1.
- branch_taken_i held high across a miss:
  - flush_o=0 while stall_o=1.
  - flush_o=1 on the first cycle after REFILL.
- rst_i asserted mid-WAIT:
  - All outputs return to reset values asynchronously.
  - A late mem_ack_i after reset causes no REFILL.
